// File: rtl/switch_button_in.sv
// Switch/button input port: two-flop synchronisers, tick-sampled debounce,
// sticky W1C press flags. Define SWBTN_IRQ_EN to build the mask register and irq.
module switch_button_in #(
  parameter logic [15:0] SAMPLE_DIV = 16'd50000,
  parameter int          SW_W       = 24,
  parameter int          BTN_W      = 5
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic [31:0]       addr,
  input  logic              we,
  input  logic [31:0]       wdata,
  output logic [31:0]       rdata,
  input  logic [SW_W-1:0]   sw,
  input  logic [BTN_W-1:0]  btn,
  output logic              irq
);

  localparam int          N    = SW_W + BTN_W;
  localparam logic [15:0] LAST = SAMPLE_DIV - 16'd1;

  logic [N-1:0]     raw;
  logic [N-1:0]     sync1_reg, sync2_reg, sample_prev_reg;
  logic [N-1:0]     deb_reg, deb_next;
  logic [15:0]      presc_reg, presc_next;
  logic             tick;
  logic [SW_W-1:0]  sw_deb;
  logic [BTN_W-1:0] btn_deb, btn_deb_next, btn_rise;
  logic [BTN_W-1:0] press_reg, press_next, press_clr;
  logic [BTN_W-1:0] mask_rd;
  logic             unused_bits;

  assign raw        = {btn, sw};
  assign tick       = (presc_reg == LAST);
  assign presc_next = tick ? 16'd0 : presc_reg + 16'd1;

  // A level is accepted only when two consecutive ticks agree.
  genvar gi;
  generate
    for (gi = 0; gi < N; gi++) begin : g_deb
      assign deb_next[gi] = (tick && (sync2_reg[gi] == sample_prev_reg[gi]))
                            ? sync2_reg[gi] : deb_reg[gi];
    end
  endgenerate

  assign sw_deb       = deb_reg[SW_W-1:0];
  assign btn_deb      = deb_reg[N-1:SW_W];
  assign btn_deb_next = deb_next[N-1:SW_W];
  assign btn_rise     = btn_deb_next & ~btn_deb;

  // Set is ORed in after the clear so a coincident press is never lost.
  assign press_clr  = (we && addr[3:2] == 2'd2) ? wdata[BTN_W-1:0] : '0;
  assign press_next = (press_reg & ~press_clr) | btn_rise;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sync1_reg       <= '0;
      sync2_reg       <= '0;
      sample_prev_reg <= '0;
      deb_reg         <= '0;
      presc_reg       <= '0;
      press_reg       <= '0;
    end else begin
      sync1_reg <= raw;
      sync2_reg <= sync1_reg;
      presc_reg <= presc_next;
      if (tick)
        sample_prev_reg <= sync2_reg;
      deb_reg   <= deb_next;
      press_reg <= press_next;
    end
  end

`ifdef SWBTN_IRQ_EN
  logic [BTN_W-1:0] mask_reg;
  logic             irq_reg;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      mask_reg <= '0;
      irq_reg  <= 1'b0;
    end else begin
      if (we && addr[3:2] == 2'd3)
        mask_reg <= wdata[BTN_W-1:0];
      irq_reg <= |(press_reg & mask_reg);
    end
  end

  assign mask_rd = mask_reg;
  assign irq     = irq_reg;
`else
  assign mask_rd = '0;
  assign irq     = 1'b0;
`endif

  always_comb begin
    rdata = '0;
    case (addr[3:2])
      2'd0:    rdata = 32'(sw_deb);
      2'd1:    rdata = 32'(btn_deb);
      2'd2:    rdata = 32'(press_reg);
      default: rdata = 32'(mask_rd);
    endcase
  end

  // Only addr[3:2] and the low wdata bits matter; the rest are absorbed here.
  assign unused_bits = ^{addr[31:4], addr[1:0], wdata};

endmodule

// File: tb/tb_switch_button_in.sv
// Scoreboard bench for switch_button_in at SAMPLE_DIV=4; irq/mask checks
// follow SWBTN_IRQ_EN the same way the design does.
module tb_switch_button_in;

  logic        clk = 1'b0;
  logic        rst_n;
  logic [31:0] addr;
  logic        we;
  logic [31:0] wdata;
  logic [31:0] rdata;
  logic [23:0] sw;
  logic [4:0]  btn;
  logic        irq;

  switch_button_in #(.SAMPLE_DIV(16'd4), .SW_W(24), .BTN_W(5)) dut (
    .clk(clk), .rst_n(rst_n), .addr(addr), .we(we), .wdata(wdata),
    .rdata(rdata), .sw(sw), .btn(btn), .irq(irq)
  );

  always #50 clk = ~clk;

  typedef struct {
    logic        is_irq;
    logic [31:0] a;
    logic [31:0] exp;
    string       name;
  } item_t;

  item_t q[$];
  int    vecs = 0;
  int    errs = 0;
  int    cyc  = 0;
  logic  chk_stb = 1'b0;

  // Posedges since reset release; sample ticks land on multiples of 4.
  always @(posedge clk) begin
    if (!rst_n) cyc = 0;
    else        cyc = cyc + 1;
  end

  // Monitor: each strobe means the DUT is presenting a response to compare.
  always @(posedge chk_stb) begin
    item_t       e;
    logic [31:0] act;
    if (q.size() == 0) begin
      errs = errs + 1;
      $display("FAIL scoreboard_empty: strobe with no expected value queued");
    end else begin
      e   = q.pop_front();
      act = e.is_irq ? {31'b0, irq} : rdata;
      vecs = vecs + 1;
      if (act !== e.exp) begin
        errs = errs + 1;
        $display("FAIL %s: addr=%h got=%h expected=%h", e.name, e.a, act, e.exp);
      end else begin
        $display("vec %0d %s: addr=%h value=%h ok", vecs, e.name, e.a, act);
      end
    end
  end

  task automatic chk(input logic is_irq, input logic [31:0] a,
                     input logic [31:0] exp, input string name);
    item_t e;
    addr = a;
    #2;
    e.is_irq = is_irq; e.a = a; e.exp = exp; e.name = name;
    q.push_back(e);
    chk_stb = 1'b1;
    #2;
    chk_stb = 1'b0;
    #1;
  endtask

  task automatic rd(input logic [31:0] a, input logic [31:0] exp, input string name);
    chk(1'b0, a, exp, name);
  endtask

  task automatic chk_irq(input logic exp, input string name);
    chk(1'b1, addr, {31'b0, exp}, name);
  endtask

  // Called at a negedge; the write commits on the next posedge.
  task automatic wr(input logic [31:0] a, input logic [31:0] d);
    addr = a; wdata = d; we = 1'b1;
    @(negedge clk);
    we = 1'b0; wdata = '0;
  endtask

  task automatic wait_tick();
    bit found = 1'b0;
    for (int i = 0; i < 8 && !found; i++) begin
      @(negedge clk);
      if (cyc % 4 == 0) found = 1'b1;
    end
    if (!found) begin
      vecs = vecs + 1;
      errs = errs + 1;
      $display("FAIL wait_tick: no tick edge within 8 cycles, cyc=%0d", cyc);
    end
  endtask

  initial begin
    rst_n = 1'b1; sw = 24'hABCDEF; btn = 5'h1F;
    addr = '0; we = 1'b0; wdata = '0;
    #10 rst_n = 1'b0;
    #10;
    rd(32'h0, 32'h0, "rst_sw");
    rd(32'h4, 32'h0, "rst_btn");
    rd(32'h8, 32'h0, "rst_press");
    rd(32'hC, 32'h0, "rst_mask");
    chk_irq(1'b0, "rst_irq");

    repeat (3) @(negedge clk);
    rst_n = 1'b1;
    repeat (12) @(negedge clk);
    rd(32'h0, 32'h00ABCDEF, "sw_after_rst");
    rd(32'h8, 32'h1F, "press_held_thru_rst");
    rd(32'h4, 32'h1F, "btn_after_rst");

    sw = 24'h000001;
    repeat (10) @(negedge clk);
    rd(32'h0, 32'h1, "sw_settled");
    sw[0] = 1'b0;
    repeat (2) begin @(negedge clk); rd(32'h0, 32'h1, "sw_glitch_low"); end
    sw[0] = 1'b1;
    repeat (8) begin @(negedge clk); rd(32'h0, 32'h1, "sw_glitch_after"); end

    wr(32'h0, 32'hFFFFFFFF);
    rd(32'h0, 32'h1, "sw_write_ignored");
    wr(32'h4, 32'h0);
    rd(32'h4, 32'h1F, "btn_write_ignored");

    btn = 5'h0;
    repeat (12) @(negedge clk);
    rd(32'h4, 32'h0, "btn_released");
    rd(32'h8, 32'h1F, "press_sticky");
    wr(32'h8, 32'h1F);
    rd(32'h8, 32'h0, "press_w1c_all");

    btn = 5'h04;
    repeat (12) @(negedge clk);
    rd(32'h4, 32'h4, "btn2_down");
    rd(32'h8, 32'h4, "press2_set");
    repeat (8) @(negedge clk);
    btn = 5'h0;
    repeat (12) @(negedge clk);
    rd(32'h4, 32'h0, "btn2_up");
    rd(32'h8, 32'h4, "press2_kept");
    wr(32'h8, 32'h4);
    rd(32'h8, 32'h0, "press2_cleared");

    btn = 5'h03;
    repeat (12) @(negedge clk);
    btn = 5'h0;
    repeat (12) @(negedge clk);
    rd(32'h8, 32'h3, "press_3");
    wr(32'h8, 32'h1);
    rd(32'h8, 32'h2, "press_clr_bit0");
    rd(32'h0000000B, 32'h2, "alias_low_bits");
    rd(32'hFFFFFF08, 32'h2, "alias_high_bits");

    // btn[1] set right after a tick edge reaches btn_deb on the 8th edge.
    wait_tick();
    btn = 5'h02;
    repeat (7) @(negedge clk);
    rd(32'h4, 32'h0, "btn1_not_yet");
    wr(32'h8, 32'h2);
    rd(32'h4, 32'h2, "btn1_rose");
    rd(32'h8, 32'h2, "set_wins_clear");

    btn = 5'h0;
    repeat (12) @(negedge clk);
    wr(32'h8, 32'h1F);
    rd(32'h8, 32'h0, "press_clear_all");

`ifdef SWBTN_IRQ_EN
    wr(32'hC, 32'h10);
    rd(32'hC, 32'h10, "mask_write");
    btn = 5'h01;
    repeat (12) @(negedge clk);
    rd(32'h8, 32'h1, "press0_masked");
    chk_irq(1'b0, "irq_masked");
    wait_tick();
    btn = 5'h11;
    repeat (8) @(negedge clk);
    rd(32'h8, 32'h11, "press4_set");
    chk_irq(1'b0, "irq_lag");
    @(negedge clk);
    chk_irq(1'b1, "irq_rise");
    wr(32'h8, 32'h10);
    rd(32'h8, 32'h1, "press4_cleared");
    chk_irq(1'b1, "irq_fall_lag");
    @(negedge clk);
    chk_irq(1'b0, "irq_fall");
`else
    wr(32'hC, 32'hFFFFFFFF);
    rd(32'hC, 32'h0, "mask_absent");
    btn = 5'h11;
    repeat (12) @(negedge clk);
    rd(32'h8, 32'h11, "press_no_irq");
    chk_irq(1'b0, "irq_tied_low");
`endif

    btn = 5'h0;
    repeat (12) @(negedge clk);
    wr(32'h8, 32'h1F);
    btn = 5'h08;
    repeat (12) @(negedge clk);
    rd(32'h8, 32'h8, "press3_set");
`ifdef SWBTN_IRQ_EN
    wr(32'hC, 32'h1F);
    @(negedge clk);
    chk_irq(1'b1, "irq_before_rst");
`endif

    // Async reset mid-debounce, checked before the next clock edge.
    sw = 24'h000005;
    repeat (5) @(negedge clk);
    #20 rst_n = 1'b0;
    rd(32'h0, 32'h0, "async_rst_sw");
    rd(32'h4, 32'h0, "async_rst_btn");
    rd(32'h8, 32'h0, "async_rst_press");
    rd(32'hC, 32'h0, "async_rst_mask");
    chk_irq(1'b0, "async_rst_irq");
    @(negedge clk);
    rst_n = 1'b1;
    repeat (12) @(negedge clk);
    rd(32'h0, 32'h5, "post_rst_sw");
    rd(32'h4, 32'h8, "post_rst_btn");
    rd(32'h8, 32'h8, "post_rst_press");
    rd(32'hC, 32'h0, "post_rst_mask");
    chk_irq(1'b0, "post_rst_irq");

    #10;
    if (q.size() != 0) begin
      errs = errs + 1;
      $display("FAIL scoreboard_leftover: %0d entries pending, expected 0", q.size());
    end
    $display("== %0d vectors applied, %0d miscompares ==", vecs, errs);
    $finish;
  end

endmodule
